// File: rtl/fp16_pkg.sv
// Shared fp16 constants, field widths, accumulator state encoding and a
// leading-zero counter used by the adder's normalizer.
package fp16_pkg;

   localparam int          SIGN_W          = 1;
   localparam int          EXP_W           = 5;
   localparam int          MAN_W           = 10;
   localparam int          FP16_BIAS       = 15;
   localparam logic [4:0]  FP16_EXP_MAX    = 5'd31;
   localparam logic [15:0] FP16_MAX_FINITE = 16'h7BFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic [3:0] lzc15(input logic [14:0] v);
      logic [3:0] n;
      n = 4'd15;
      for (int i = 0; i < 15; i++) begin
         if (v[i]) n = 4'(14 - i);
      end
      return n;
   endfunction

endpackage

// File: rtl/accum_half_precision_if.sv
// Product-in / sum-out handshake bundle for the fp16 dot-product accumulator.
interface accum_half_precision_if;

   logic [15:0] i_Product;
   logic        i_Exception;
   logic        i_Valid;
   logic        o_Ready;
   logic        i_Clear;
   logic [15:0] o_Sum;
   logic        o_Exception;
   logic        o_Valid;
   logic        i_Ready;

   modport slave (
      input  i_Product, i_Exception, i_Valid, i_Clear, i_Ready,
      output o_Ready, o_Sum, o_Exception, o_Valid
   );

   modport master (
      output i_Product, i_Exception, i_Valid, i_Clear, i_Ready,
      input  o_Ready, o_Sum, o_Exception, o_Valid
   );

endinterface

// File: rtl/add_half_precision.sv
// Combinational fp16 adder: flush-to-zero, saturating, truncating by default.
// Define ROUND_NEAREST_EN for round-to-nearest-even using guard/round/sticky.
module add_half_precision
   import fp16_pkg::*;
(
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] sum_o,
   output logic        exc_o
);

   logic              a_zero, b_zero, a_spec, b_spec, swap;
   logic [15:0]       big, sml;
   logic [EXP_W-1:0]  d;
   logic [34:0]       sml_sh;
   logic [13:0]       ma_x, mb_x;
   logic [14:0]       mag;
   logic [3:0]        lz;
   logic signed [6:0] e_res;
   logic [MAN_W-1:0]  man;
`ifdef ROUND_NEAREST_EN
   logic [13:0]       norm;
   logic              rnd_up, man_c;
`endif

   always_comb begin
      a_zero = (a_i[14:10] == 5'd0);
      b_zero = (b_i[14:10] == 5'd0);
      a_spec = (a_i[14:10] == FP16_EXP_MAX);
      b_spec = (b_i[14:10] == FP16_EXP_MAX);
      swap   = (b_i[14:0] > a_i[14:0]);
      big    = swap ? b_i : a_i;
      sml    = swap ? a_i : b_i;
      d      = big[14:10] - sml[14:10];
      ma_x   = {1'b1, big[9:0], 3'b000};
      // Bits shifted below the round position collapse into one sticky bit.
      sml_sh = {1'b1, sml[9:0], 24'd0} >> d;
      mb_x   = {sml_sh[34:22], |sml_sh[21:0]};
      mag    = (big[15] ^ sml[15]) ? ({1'b0, ma_x} - {1'b0, mb_x})
                                   : ({1'b0, ma_x} + {1'b0, mb_x});
      lz     = lzc15(mag);
      e_res  = $signed({2'b00, big[14:10]}) + 7'sd1 - $signed({3'b000, lz});
`ifdef ROUND_NEAREST_EN
      norm          = 14'(mag << lz);
      rnd_up        = norm[3] & (norm[4] | (|norm[2:0]));
      {man_c, man}  = {1'b0, norm[13:4]} + {10'd0, rnd_up};
      e_res         = e_res + (man_c ? 7'sd1 : 7'sd0);
`else
      man           = 10'((mag << lz) >> 4);
`endif

      sum_o = 16'h0000;
      exc_o = 1'b0;
      if (a_spec || b_spec) begin
         sum_o = {a_spec ? a_i[15] : b_i[15], FP16_MAX_FINITE[14:0]};
         exc_o = 1'b1;
      end else if (a_zero && b_zero) begin
         sum_o = 16'h0000;
      end else if (a_zero) begin
         sum_o = b_i;
      end else if (b_zero) begin
         sum_o = a_i;
      end else if (mag == 15'd0) begin
         sum_o = 16'h0000;
      end else if (e_res > 7'sd30) begin
         sum_o = {big[15], FP16_MAX_FINITE[14:0]};
         exc_o = 1'b1;
      end else if (e_res < 7'sd1) begin
         sum_o = 16'h0000;
      end else begin
         sum_o = {big[15], e_res[4:0], man};
      end
   end

endmodule

// File: rtl/accum_half_precision.sv
// Sums DOT_LEN fp16 products into one held result; rounding follows the
// ROUND_NEAREST_EN build option of the adder.
//   state | meaning
//   IDLE  | waiting for first term of a dot product
//   ACCUM | adding subsequent terms, count < DOT_LEN
//   DONE  | result presented with o_Valid until i_Ready
module accum_half_precision
   import fp16_pkg::*;
#(
   parameter int DOT_LEN = 4
)(
   input logic                   i_Clk,
   input logic                   i_Reset,
   accum_half_precision_if.slave bus
);

   localparam logic [3:0] LEN = 4'(DOT_LEN);

   state_t      state_q, state_d;
   logic [15:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        exc_q, exc_d;
   logic        accept;
   logic [15:0] add_sum;
   logic        add_exc;

   add_half_precision u_add (
      .a_i   (acc_q),
      .b_i   (bus.i_Product),
      .sum_o (add_sum),
      .exc_o (add_exc)
   );

   assign accept = bus.i_Valid & bus.o_Ready;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      exc_d   = exc_q;
      unique case (state_q)
         IDLE, ACCUM: begin
            if (bus.i_Clear) begin
               state_d = IDLE;
               acc_d   = 16'h0000;
               cnt_d   = 4'd0;
               exc_d   = 1'b0;
            end else if (accept) begin
               if (state_q == IDLE) begin
                  acc_d = bus.i_Product;
                  exc_d = bus.i_Exception;
                  cnt_d = 4'd1;
               end else begin
                  acc_d = add_sum;
                  exc_d = exc_q | bus.i_Exception | add_exc;
                  cnt_d = cnt_q + 4'd1;
               end
               state_d = (cnt_d == LEN) ? DONE : ACCUM;
            end
         end
         // Clear is ignored here so a presented result is never dropped.
         DONE: begin
            if (bus.i_Ready) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q <= IDLE;
         acc_q   <= 16'h0000;
         cnt_q   <= 4'd0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         exc_q   <= exc_d;
      end
   end

   assign bus.o_Ready     = (state_q != DONE);
   assign bus.o_Valid     = (state_q == DONE);
   assign bus.o_Sum       = acc_q;
   assign bus.o_Exception = exc_q;

endmodule

// File: tb/tb_accum_half_precision.sv
// Directed and random dot products checked against a real-arithmetic fp16 model.
module tb_accum_half_precision;
   import fp16_pkg::*;

   localparam int DOT_LEN = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   accum_half_precision_if bus ();

   accum_half_precision #(.DOT_LEN(DOT_LEN)) dut (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic real p2(input int e);
      real r;
      r = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else        for (int i = 0; i < -e; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real fp2r(input logic [15:0] h);
      real m;
      if (h[14:10] == 5'd0) return 0.0;
      m = (1024.0 + real'(h[9:0])) / 1024.0 * p2(int'(h[14:10]) - FP16_BIAS);
      return h[15] ? -m : m;
   endfunction

   // Returns {exception, fp16} for an exact real value.
   function automatic logic [16:0] r2fp(input real x);
      real  ax, m;
      int   e, mi;
      logic s;
`ifdef ROUND_NEAREST_EN
      real  rem;
`endif
      if (x == 0.0) return 17'h0;
      s  = (x < 0.0);
      ax = s ? -x : x;
      e  = 0;
      while (ax >= p2(e + 1)) e++;
      while (ax < p2(e)) e--;
      m  = ax / p2(e) * 1024.0;
      mi = $rtoi(m);
`ifdef ROUND_NEAREST_EN
      rem = m - real'(mi);
      if (rem > 0.5 || (rem == 0.5 && mi[0])) mi++;
      if (mi == 2048) begin
         mi = 1024;
         e++;
      end
`endif
      if (e + FP16_BIAS > 30) return {1'b1, s, 15'h7BFF};
      if (e + FP16_BIAS < 1)  return 17'h0;
      return {1'b0, s, 5'(e + FP16_BIAS), 10'(mi - 1024)};
   endfunction

   function automatic logic [16:0] model_add(input logic [15:0] a, input logic [15:0] b);
      if (a[14:10] == 5'd31) return {1'b1, a[15], 15'h7BFF};
      if (b[14:10] == 5'd31) return {1'b1, b[15], 15'h7BFF};
      return r2fp(fp2r(a) + fp2r(b));
   endfunction

   function automatic logic [16:0] model_dot(input logic [3:0][15:0] t, input logic [3:0] x);
      logic [15:0] acc;
      logic        e;
      logic [16:0] r;
      acc = t[0];
      e   = x[0];
      for (int i = 1; i < DOT_LEN; i++) begin
         r   = model_add(acc, t[i]);
         acc = r[15:0];
         e   = e | x[i] | r[16];
      end
      return {e, acc};
   endfunction

   function automatic logic [3:0][15:0] pk(input logic [15:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   function automatic logic [15:0] rand_fp16();
      int sel;
      sel = $urandom_range(0, 19);
      case (sel)
         0:       return 16'h0000;
         1:       return {1'($urandom), 5'd31, 10'($urandom)};
         2:       return {1'($urandom), 5'd0, 10'($urandom)};
         3, 4:    return {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
         5:       return {1'($urandom), 5'd30, 10'($urandom)};
         default: return {1'($urandom), 5'($urandom_range(12, 18)), 10'($urandom)};
      endcase
   endfunction

   task automatic feed(input logic [15:0] t, input logic x);
      bus.i_Product   = t;
      bus.i_Exception = x;
      bus.i_Valid     = 1'b1;
      tick();
      bus.i_Valid     = 1'b0;
      bus.i_Exception = 1'b0;
   endtask

   task automatic do_dot(input string tag, input logic [3:0][15:0] t, input logic [3:0] x,
                         input int maxgap, input int rdly, input bit clr_done,
                         output logic [16:0] got);
      logic [16:0] expv;
      expv = model_dot(t, x);
      for (int i = 0; i < DOT_LEN; i++) begin
         if (i > 0) repeat ($urandom_range(0, maxgap)) begin
            chk({tag, "_gap_valid"}, 16'(bus.o_Valid), 16'h0);
            tick();
         end
         feed(t[i], x[i]);
      end
      got = {bus.o_Exception, bus.o_Sum};
      chk({tag, "_valid"}, 16'(bus.o_Valid), 16'h1);
      chk({tag, "_sum"}, bus.o_Sum, expv[15:0]);
      chk({tag, "_exc"}, 16'(bus.o_Exception), 16'(expv[16]));
      bus.i_Clear = clr_done;
      repeat (rdly) begin
         tick();
         chk({tag, "_hold_valid"}, 16'(bus.o_Valid), 16'h1);
         chk({tag, "_hold_sum"}, bus.o_Sum, expv[15:0]);
      end
      bus.i_Clear = 1'b0;
      bus.i_Ready = 1'b1;
      tick();
      bus.i_Ready = 1'b0;
      chk({tag, "_valid_drop"}, 16'(bus.o_Valid), 16'h0);
   endtask

   initial begin
      logic [16:0] got;
      bus.i_Product   = 16'h0000;
      bus.i_Exception = 1'b0;
      bus.i_Valid     = 1'b0;
      bus.i_Clear     = 1'b0;
      bus.i_Ready     = 1'b0;
      #2;
      chk("rst_ready", 16'(bus.o_Ready), 16'h1);
      chk("rst_valid", 16'(bus.o_Valid), 16'h0);
      chk("rst_sum", bus.o_Sum, 16'h0000);
      chk("rst_exc", 16'(bus.o_Exception), 16'h0);
      tick();
      rst = 1'b0;
      tick();

      do_dot("basic", pk(16'h3C00, 16'h4000, 16'h3800, 16'h3800), 4'b0000, 0, 0, 0, got);
      chk("basic_const", got[15:0], 16'h4400);
      chk("basic_const_exc", 16'(got[16]), 16'h0);

      do_dot("cancel", pk(16'h4000, 16'hC000, 16'h0000, 16'h0000), 4'b0000, 0, 0, 0, got);
      chk("cancel_const", got[15:0], 16'h0000);

      do_dot("ovf", pk(16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF), 4'b0000, 0, 0, 0, got);
      chk("ovf_const", got[15:0], 16'h7BFF);
      chk("ovf_const_exc", 16'(got[16]), 16'h1);

      do_dot("inexc", pk(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00), 4'b0010, 0, 0, 0, got);
      chk("inexc_const", got[15:0], 16'h4400);
      chk("inexc_const_exc", 16'(got[16]), 16'h1);
      do_dot("noexc", pk(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00), 4'b0000, 0, 0, 0, got);
      chk("noexc_const_exc", 16'(got[16]), 16'h0);

      // Backpressure in DONE with a term waiting
      for (int i = 0; i < DOT_LEN; i++) feed(16'h3C00, 1'b0);
      bus.i_Product = 16'h3C00;
      bus.i_Valid   = 1'b1;
      repeat (3) begin
         tick();
         chk("bp_ready", 16'(bus.o_Ready), 16'h0);
         chk("bp_valid", 16'(bus.o_Valid), 16'h1);
         chk("bp_sum", bus.o_Sum, 16'h4400);
      end
      bus.i_Ready = 1'b1;
      tick();
      bus.i_Ready = 1'b0;
      chk("bp_release_valid", 16'(bus.o_Valid), 16'h0);
      chk("bp_release_ready", 16'(bus.o_Ready), 16'h1);
      tick();
      bus.i_Valid = 1'b0;
      for (int i = 1; i < DOT_LEN; i++) feed(16'h3C00, 1'b0);
      chk("bp_next_valid", 16'(bus.o_Valid), 16'h1);
      chk("bp_next_sum", bus.o_Sum, 16'h4400);
      bus.i_Ready = 1'b1;
      tick();
      bus.i_Ready = 1'b0;

      // Clear after two terms, with a term offered in the same cycle
      feed(16'h4000, 1'b1);
      feed(16'h4000, 1'b0);
      bus.i_Clear   = 1'b1;
      bus.i_Valid   = 1'b1;
      bus.i_Product = 16'h4000;
      tick();
      bus.i_Clear = 1'b0;
      bus.i_Valid = 1'b0;
      chk("clr_valid", 16'(bus.o_Valid), 16'h0);
      do_dot("clr", pk(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00), 4'b0000, 0, 2, 1, got);
      chk("clr_const", got[15:0], 16'h4400);
      chk("clr_const_exc", 16'(got[16]), 16'h0);

      // Asynchronous reset mid-accumulation
      feed(16'h3C00, 1'b0);
      feed(16'h3C00, 1'b1);
      feed(16'h3C00, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_ready", 16'(bus.o_Ready), 16'h1);
      chk("arst_valid", 16'(bus.o_Valid), 16'h0);
      chk("arst_sum", bus.o_Sum, 16'h0000);
      chk("arst_exc", 16'(bus.o_Exception), 16'h0);
      tick();
      rst = 1'b0;
      tick();
      do_dot("post_rst", pk(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00), 4'b0000, 0, 0, 0, got);
      chk("post_rst_const", got[15:0], 16'h4400);

      do_dot("round", pk(16'h3C00, 16'h1200, 16'h0000, 16'h0000), 4'b0000, 0, 0, 0, got);
`ifdef ROUND_NEAREST_EN
      chk("round_const", got[15:0], 16'h3C01);
`else
      chk("round_const", got[15:0], 16'h3C00);
`endif

      for (int n = 0; n < 40; n++) begin
         logic [3:0][15:0] t;
         logic [3:0]       x;
         for (int i = 0; i < DOT_LEN; i++) begin
            t[i] = rand_fp16();
            x[i] = ($urandom_range(0, 9) == 0);
         end
         do_dot("rand", t, x, 2, $urandom_range(0, 3), 1'($urandom), got);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
